// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
// The RST_SEQ_REVERSE_ASSERT_EN build uses the SHUTDOWN state; otherwise it is never entered.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_RDY,
      DONE,
      ERROR,
      SHUTDOWN
   } state_t;

   localparam int MAX_STAGES = 8;

   // Counter must reach max(hold, timeout) - 1; never narrower than one bit.
   function automatic int cnt_width(input int hold, input int timeout);
      int m;
      m = (hold > timeout) ? hold : timeout;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear and terminal-count compare, shared by the hold
// interval and the per-stage ready timeout.
module rst_seq_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] tc_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Releases subsystem resets one stage at a time after a hold interval, waiting for each ready ack.
// Define RST_SEQ_REVERSE_ASSERT_EN to re-assert stages highest-first on a soft reset request.
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES     = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 soft_rst_req,
   input  logic [NUM_STAGES-1:0]                stage_ready,
   output logic [NUM_STAGES-1:0]                stage_rst,
   output logic                                 all_released,
   output logic                                 busy,
   output logic                                 timeout_err,
   output logic [idx_width(NUM_STAGES)-1:0]     err_stage
);

   localparam int CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
   localparam int IW = idx_width(NUM_STAGES);
   localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] TO_TC    = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

   state_t                state_q, state_n;
   logic [IW-1:0]         idx_q, idx_n;
   logic [NUM_STAGES-1:0] stage_rst_d;
   logic                  all_released_d, busy_d, timeout_err_d;
   logic [IW-1:0]         err_stage_d;
   logic                  clr, inc, tc;
   logic [CW-1:0]         tc_val;

   rst_seq_timer #(.W(CW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .inc    (inc),
      .tc_val (tc_val),
      .tc     (tc)
   );

`ifdef RST_SEQ_REVERSE_ASSERT_EN
   // Current stage_rst with its highest released bit re-asserted.
   logic [NUM_STAGES-1:0] shut_step;
   logic                  shut_found;

   always_comb begin
      shut_step  = stage_rst;
      shut_found = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (!shut_found && !stage_rst[i]) begin
            shut_step[i] = 1'b1;
            shut_found   = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_n        = state_q;
      idx_n          = idx_q;
      stage_rst_d    = stage_rst;
      all_released_d = all_released;
      busy_d         = busy;
      timeout_err_d  = timeout_err;
      err_stage_d    = err_stage;
      clr            = 1'b0;
      inc            = 1'b0;
      tc_val         = (state_q == HOLD) ? HOLD_TC : TO_TC;

      case (state_q)
         HOLD: begin
            if (tc) begin
               state_n        = WAIT_RDY;
               idx_n          = '0;
               stage_rst_d[0] = 1'b0;
               clr            = 1'b1;
            end else begin
               inc = 1'b1;
            end
         end
         WAIT_RDY: begin
            // A ready ack takes precedence over a timeout in the same cycle.
            if (stage_ready[idx_q]) begin
               if (idx_q == IDX_LAST) begin
                  state_n        = DONE;
                  stage_rst_d    = '0;
                  all_released_d = 1'b1;
                  busy_d         = 1'b0;
               end else begin
                  idx_n              = idx_q + 1'b1;
                  stage_rst_d[idx_n] = 1'b0;
                  clr                = 1'b1;
               end
            end else if (tc) begin
               state_n       = ERROR;
               timeout_err_d = 1'b1;
               err_stage_d   = idx_q;
               busy_d        = 1'b0;
            end else begin
               inc = 1'b1;
            end
         end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
         SHUTDOWN: begin
            stage_rst_d = shut_step;
            if (&shut_step) begin
               state_n = HOLD;
               clr     = 1'b1;
            end
         end
`endif
         default: ;
      endcase

`ifdef RST_SEQ_REVERSE_ASSERT_EN
      if (soft_rst_req && state_q != SHUTDOWN) begin
         stage_rst_d = shut_step;
         state_n     = (&shut_step) ? HOLD : SHUTDOWN;
`else
      if (soft_rst_req) begin
         stage_rst_d = '1;
         state_n     = HOLD;
`endif
         idx_n          = '0;
         clr            = 1'b1;
         inc            = 1'b0;
         all_released_d = 1'b0;
         busy_d         = 1'b1;
         timeout_err_d  = 1'b0;
         err_stage_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HOLD;
         idx_q        <= '0;
         stage_rst    <= '1;
         all_released <= 1'b0;
         busy         <= 1'b1;
         timeout_err  <= 1'b0;
         err_stage    <= '0;
      end else begin
         state_q      <= state_n;
         idx_q        <= idx_n;
         stage_rst    <= stage_rst_d;
         all_released <= all_released_d;
         busy         <= busy_d;
         timeout_err  <= timeout_err_d;
         err_stage    <= err_stage_d;
      end
   end

endmodule
